// File: rtl/spi_pkg.sv
// Shared SPI constants and the FIFO occupancy-width helper.
package spi_pkg;

  localparam int SPI_DATA_W     = 32;
  localparam int SPI_FIFO_DEPTH = 16;

  // Width of an occupancy count or a wrap-bit pointer for a given depth.
  function automatic int spi_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/spi_fifo_mem.sv
// FIFO storage array: one synchronous write port, one asynchronous read port.
module spi_fifo_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  // Storage is intentionally left unreset.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/spi_fifo.sv
// Show-ahead SPI FIFO with wrap-bit pointers and optional sticky status flags.
// Define SPI_FIFO_STATUS_EN to build the overflow/underflow flag registers.
module spi_fifo
  import spi_pkg::*;
#(
  parameter int WIDTH = SPI_DATA_W,
  parameter int DEPTH = SPI_FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        wr_pulse,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic                        rd_pulse,
  output logic [WIDTH-1:0]            rd_data,
  output logic [spi_cnt_w(DEPTH)-1:0] count,
  output logic                        full,
  output logic                        empty,
  output logic                        overflow,
  output logic                        underflow,
  input  logic                        clr_status
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = spi_cnt_w(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          rd_ok;
  logic          push_acc;
  logic          pop_acc;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign count = wr_ptr_q - rd_ptr_q;

  // A pop frees a slot in the same cycle, so a push while full still succeeds.
  assign rd_ok    = rd_pulse && !empty;
  assign pop_acc  = rd_ok && !clear;
  assign push_acc = wr_pulse && !clear && (!full || rd_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_acc) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_acc)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  spi_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (push_acc),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rd_data)
  );

`ifdef SPI_FIFO_STATUS_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;
  logic ovf_set;
  logic unf_set;

  assign ovf_set = wr_pulse && !clear && full && !rd_ok;
  assign unf_set = rd_pulse && !clear && empty;

  // A same-cycle clr_status wins over a new rejection.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (clr_status) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else begin
      if (ovf_set) ovf_d = 1'b1;
      if (unf_set) unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`else
  logic unused_clr_status;
  assign unused_clr_status = clr_status;
  assign overflow          = 1'b0;
  assign underflow         = 1'b0;
`endif

endmodule

// File: tb/tb_spi_fifo.sv
// Randomized and directed bench for spi_fifo against a queue-based reference model.
module tb_spi_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
`ifdef SPI_FIFO_STATUS_EN
  localparam bit STATUS = 1'b1;
`else
  localparam bit STATUS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             clear = 1'b0;
  logic             wr_pulse = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             rd_pulse = 1'b0;
  logic [WIDTH-1:0] rd_data;
  logic [4:0]       count;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             underflow;
  logic             clr_status = 1'b0;

  spi_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .wr_pulse   (wr_pulse),
    .wr_data    (wr_data),
    .rd_pulse   (rd_pulse),
    .rd_data    (rd_data),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow),
    .underflow  (underflow),
    .clr_status (clr_status)
  );

  always #5 clk = ~clk;

  // Reference model: an ordered list of queued words plus two sticky flags.
  logic [WIDTH-1:0] q[$];
  bit               m_ovf;
  bit               m_unf;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"}, 64'(count), 64'(q.size()));
    check({tag, ".empty"}, 64'(empty), 64'(q.size() == 0));
    check({tag, ".full"}, 64'(full), 64'(q.size() == DEPTH));
    check({tag, ".overflow"}, 64'(overflow), 64'(m_ovf));
    check({tag, ".underflow"}, 64'(underflow), 64'(m_unf));
    if (q.size() != 0) check({tag, ".rd_data"}, 64'(rd_data), 64'(q[0]));
  endtask

  task automatic model(input bit wr, input logic [WIDTH-1:0] wd, input bit rd,
                       input bit clr, input bit cs);
    int  sz;
    bit  pop_ok, push_ok, ovf_set, unf_set;
    sz = q.size();
    pop_ok  = 1'b0;
    push_ok = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (clr) begin
      q.delete();
    end else begin
      pop_ok  = rd && (sz > 0);
      push_ok = wr && ((sz < DEPTH) || pop_ok);
      ovf_set = wr && !push_ok;
      unf_set = rd && (sz == 0);
      if (pop_ok)  void'(q.pop_front());
      if (push_ok) q.push_back(wd);
    end
    if (STATUS) begin
      if (cs) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end else begin
        m_ovf = m_ovf | ovf_set;
        m_unf = m_unf | unf_set;
      end
    end
  endtask

  task automatic step(input string tag, input bit wr, input logic [WIDTH-1:0] wd,
                      input bit rd, input bit clr, input bit cs);
    wr_pulse   = wr;
    wr_data    = wd;
    rd_pulse   = rd;
    clear      = clr;
    clr_status = cs;
    @(posedge clk);
    #1;
    model(wr, wd, rd, clr, cs);
    wr_pulse   = 1'b0;
    rd_pulse   = 1'b0;
    clear      = 1'b0;
    clr_status = 1'b0;
    check_all(tag);
  endtask

  task automatic push(input string tag, input logic [WIDTH-1:0] wd);
    step(tag, 1'b1, wd, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop(input string tag);
    step(tag, 1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b1;

    // First push is visible the next cycle
    push("first_push", 32'hA5A5_0001);

    // Fill, reject one extra push, then drain in order
    step("flush", 1'b0, '0, 1'b0, 1'b1, 1'b1);
    for (int i = 1; i <= DEPTH; i++) push("fill", WIDTH'(i));
    push("push_full", 32'h0000_DEAD);
    check("full_flag", 64'(full), 64'd1);
    for (int i = 1; i <= DEPTH; i++) begin
      check("drain_head", 64'(rd_data), 64'(i));
      pop("drain");
    end
    check("drained_empty", 64'(empty), 64'd1);

    // Push and pop together while full
    step("flush2", 1'b0, '0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < DEPTH; i++) push("fill2", 32'h100 + WIDTH'(i));
    step("push_pop_full", 1'b1, 32'h77, 1'b1, 1'b0, 1'b0);
    check("push_pop_full_cnt", 64'(count), 64'(DEPTH));
    for (int i = 0; i < DEPTH - 1; i++) pop("drain2");
    check("tail_word", 64'(rd_data), 64'h77);
    pop("drain_last");

    // Underflow, then clr_status beats a same-cycle pop on empty
    pop("pop_empty");
    step("clr_status_pop", 1'b0, '0, 1'b1, 1'b0, 1'b1);
    check("underflow_cleared", 64'(underflow), 64'd0);
    step("push_pop_empty", 1'b1, 32'h55, 1'b1, 1'b0, 1'b0);
    pop("drain3");

    // Pointer wrap keeps order; clear leaves flags alone
    for (int i = 0; i < 10; i++) push("wrap_a", 32'h200 + WIDTH'(i));
    for (int i = 0; i < 10; i++) pop("wrap_pop");
    for (int i = 0; i < 10; i++) push("wrap_b", 32'h300 + WIDTH'(i));
    check("wrap_count", 64'(count), 64'd10);
    step("clear", 1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle discards the queue
    for (int i = 0; i < 5; i++) push("pre_reset", 32'h400 + WIDTH'(i));
    #3;
    reset = 1'b0;
    #1;
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    check_all("async_reset");
    @(posedge clk);
    #2;
    reset = 1'b1;
    push("post_reset", 32'hBEEF_0001);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      bit               wr, rd, clr, cs;
      logic [WIDTH-1:0] wd;
      wr  = ($urandom_range(99) < 50);
      rd  = ($urandom_range(99) < 45);
      clr = ($urandom_range(39) == 0);
      cs  = ($urandom_range(15) == 0);
      wd  = $urandom;
      step("random", wr, wd, rd, clr, cs);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
